// File: rtl/hilo_muldiv_if.sv
// Decoder-to-muldiv bundle: op flags and operands in, status, HI/LO and
// read data out.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             MULT_FLAG;
    logic             MULTU_FLAG;
    logic             DIV_FLAG;
    logic             DIVU_FLAG;
    logic             MTHI_FLAG;
    logic             MTLO_FLAG;
    logic             MFHI_FLAG;
    logic             MFLO_FLAG;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    modport slave (
        input  MULT_FLAG, MULTU_FLAG, DIV_FLAG, DIVU_FLAG,
        input  MTHI_FLAG, MTLO_FLAG, MFHI_FLAG, MFLO_FLAG,
        input  rs_data, rt_data,
        output stall, busy, done, div_zero,
        output hi, lo, rd_data
    );

    modport master (
        output MULT_FLAG, MULTU_FLAG, DIV_FLAG, DIVU_FLAG,
        output MTHI_FLAG, MTLO_FLAG, MFHI_FLAG, MFLO_FLAG,
        output rs_data, rt_data,
        input  stall, busy, done, div_zero,
        input  hi, lo, rd_data
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers.
// Operands are made unsigned up front; signs are reapplied at commit.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic          clk,
    input logic          rst,
    hilo_muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic             start;
    logic             is_sgn;
    logic             is_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign start  = bus.MULT_FLAG | bus.MULTU_FLAG
                  | bus.DIV_FLAG  | bus.DIVU_FLAG;
    assign is_sgn = bus.MULT_FLAG | bus.DIV_FLAG;
    assign is_div = bus.DIV_FLAG  | bus.DIVU_FLAG;

    assign mag_a = (is_sgn && bus.rs_data[WIDTH-1])
                 ? -bus.rs_data : bus.rs_data;
    assign mag_b = (is_sgn && bus.rt_data[WIDTH-1])
                 ? -bus.rt_data : bus.rt_data;

    // Multiply: acc = {partial, multiplier}; divide: acc = {rem, dividend/quotient}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_sh - {1'b0, opb_q};
    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
                    opb_d   = is_div ? mag_b : mag_a;
                    sa_d    = is_sgn & bus.rs_data[WIDTH-1];
                    sb_d    = is_sgn & bus.rt_data[WIDTH-1];
                    div_d   = is_div;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    if (bus.MTHI_FLAG) hi_d = bus.rs_data;
                    if (bus.MTLO_FLAG) lo_d = bus.rs_data;
                end
            end
            CALC: begin
                if (div_q) begin
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (div_q) begin
                    // A zero divisor leaves the dividend magnitude in rem
                    hi_d = sa_q ? -rem : rem;
                    if (opb_q == '0) begin
                        dz_d = 1'b1;
                        lo_d = '1;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? -quo : quo;
                    end
                end else begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? -acc_q : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.stall    = ((state_q == IDLE) && start) || (state_q == CALC);
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.rd_data  = bus.MFHI_FLAG ? hi_q
                        : bus.MFLO_FLAG ? lo_q : '0;
endmodule
